// File: rtl/sum_acc_pkg.sv
// Shared types and sizing rules for the sum_accumulator block.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int N_SAMPLES_DEF = 4;
  localparam int ACC_W_DEF     = 12;

  // The counter must be able to hold N_SAMPLES itself, not just N_SAMPLES-1.
  function automatic int count_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

endpackage

// File: rtl/sum_acc_add.sv
// Combinational add/overflow datapath for sum_accumulator.
// Define SUM_ACCUMULATOR_SAT_EN to saturate on overflow; the default build wraps.
module sum_acc_add
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [8:0]       in_sum,
  output logic [ACC_W-1:0] next_acc,
  output logic             ovf_now
);

  logic [ACC_W:0] wide;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    wide    = {1'b0, acc} + {{(ACC_W-8){1'b0}}, in_sum};
    ovf_now = wide[ACC_W];
`ifdef SUM_ACCUMULATOR_SAT_EN
    next_acc = ovf_now ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    next_acc = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 9-bit sums into an ACC_W-bit result with valid/ready
// handshakes. Overflow behaviour is selected by SUM_ACCUMULATOR_SAT_EN.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [8:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = count_w(N_SAMPLES);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] next_acc;
  logic             ovf_now;

  sum_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc      (acc),
    .in_sum   (in_sum),
    .next_acc (next_acc),
    .ovf_now  (ovf_now)
  );

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign out_acc  = acc;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= next_acc;
            count <= count + 1'b1;
            ovf   <= ovf | ovf_now;
            if (count == CNT_W'(N_SAMPLES - 1)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (default and ACC_W=10 builds).
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear, in_valid, out_ready;
  logic [8:0]  in_sum;
  logic        in_ready, out_valid, ovf, busy;
  logic [11:0] out_acc;

  logic        start2, in_valid2, out_ready2;
  logic [8:0]  in_sum2;
  logic        in_ready2, out_valid2, ovf2, busy2;
  logic [9:0]  out_acc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sum_accumulator u_dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .ovf(ovf), .busy(busy)
  );

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start2), .clear(1'b0),
    .in_valid(in_valid2), .in_sum(in_sum2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2),
    .ovf(ovf2), .busy(busy2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_sum   = 9'(v);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    int sums [4];
    rst = 1'b1; start = 0; clear = 0; in_valid = 0; in_sum = 0; out_ready = 0;
    start2 = 0; in_valid2 = 0; in_sum2 = 0; out_ready2 = 0;
    cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_acc", out_acc, 0);
    rst = 1'b0;
    cyc();

    // Basic run with in_valid held high: 100+200+511+0 = 811.
    do_start();
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    sums = '{100, 200, 511, 0};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sum = 9'(sums[i]);
      if (i == 3) check("pre_last_out_valid", out_valid, 0);
      cyc();
    end
    check("basic_out_valid", out_valid, 1);
    check("basic_out_acc", out_acc, 811);
    check("basic_ovf", ovf, 0);
    check("basic_in_ready", in_ready, 0);
    in_valid = 1'b0;
    drain();
    check("basic_drained_valid", out_valid, 0);
    check("basic_drained_busy", busy, 0);

    // Gapped input, then backpressure with a stray sum presented in HOLD.
    do_start();
    sums = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      feed(sums[i]);
      if (i < 3) begin
        in_sum = 9'd255;
        cyc();
      end
    end
    check("gap_out_valid", out_valid, 1);
    check("gap_out_acc", out_acc, 100);
    in_valid = 1'b1;
    in_sum   = 9'd255;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_out_acc", out_acc, 100);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    check("hold_count", int'(u_dut.count), 4);
    in_valid = 1'b0;
    drain();
    check("gap_idle_busy", busy, 0);
    check("gap_idle_valid", out_valid, 0);

    // Stray sums while IDLE must not change anything.
    in_valid = 1'b1;
    in_sum   = 9'd255;
    repeat (3) cyc();
    in_valid = 1'b0;
    check("idle_out_acc", out_acc, 100);
    check("idle_count", int'(u_dut.count), 4);
    check("idle_busy", busy, 0);

    // ACC_W=10 instance: 4 x 300 = 1200 overflows 1023.
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    in_valid2 = 1'b1;
    in_sum2   = 9'd300;
    cyc();
    cyc();
    check("w10_ovf_600", ovf2, 0);
    cyc();
    check("w10_acc_900", out_acc2, 900);
    check("w10_ovf_900", ovf2, 0);
    cyc();
    in_valid2 = 1'b0;
    check("w10_out_valid", out_valid2, 1);
`ifdef SUM_ACCUMULATOR_SAT_EN
    check("w10_out_acc", out_acc2, 1023);
`else
    check("w10_out_acc", out_acc2, 176);
`endif
    check("w10_ovf", ovf2, 1);
    out_ready2 = 1'b1;
    cyc();
    out_ready2 = 1'b0;
    check("w10_ovf_sticky_idle", ovf2, 1);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    check("w10_ovf_cleared_by_start", ovf2, 0);
    check("w10_acc_cleared_by_start", out_acc2, 0);

    // Clear together with the third accept wins.
    do_start();
    feed(5);
    feed(5);
    clear = 1'b1;
    feed(5);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_out_acc", out_acc, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_count", int'(u_dut.count), 0);
    cyc();
    check("clr_no_result", out_valid, 0);
    do_start();
    repeat (4) feed(5);
    check("clr_rerun_valid", out_valid, 1);
    check("clr_rerun_acc", out_acc, 20);
    drain();

    // Asynchronous reset mid-run, between clock edges.
    do_start();
    feed(1);
    feed(1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_acc", out_acc, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    #1 rst = 1'b0;
    cyc();
    check("arst_stays_idle", busy, 0);
    do_start();
    repeat (4) feed(1);
    check("arst_rerun_valid", out_valid, 1);
    check("arst_rerun_acc", out_acc, 4);
    check("arst_rerun_ovf", ovf, 0);
    drain();
    check("arst_final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
